inst_fetch_ctrl: RTL

Instruction fetch controller sequencing the instruction memory. Owns the fetch PC and drives the memory's combinational read address. Captures each returned word into a 2-entry prefetch buffer and hands instructions to decode over a valid/ready handshake. Sits between the instruction memory and the decode stage, and accepts redirects from branch/jump resolution.

---
 rtl/inst_fetch_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch controller with 2-entry prefetch buffer
//
// Purpose:
//   Owns the fetch PC, drives the instruction memory read address
//   combinationally, captures each returned word into a 2-entry prefetch
//   buffer and presents the buffer head to decode over valid/ready.
//   Redirects from branch/jump resolution flush the buffer and reload the PC.
//   A fetch from an out-of-range or misaligned PC produces a single fault
//   entry and parks the controller until the next redirect.
//
// Ports:
//   clk_in             in   clock, rising edge
//   reset_in           in   asynchronous active-high reset
//   mem_address_out    out  instruction memory address (0 when not fetching)
//   mem_data_in        in   instruction memory data, same cycle as address
//   redirect_valid_in  in   load a new fetch PC, flush the buffer
//   redirect_pc_in     in   redirect target
//   inst_valid_out     out  buffer head is valid
//   inst_ready_in      in   decode accepts the head
//   inst_out           out  head instruction (0 when empty)
//   inst_pc_out        out  head PC (0 when empty)
//   inst_fault_out     out  head is a fetch fault (0 when empty)
//   issued_count_out   out  saturating count of accepted heads   (INST_FETCH_PERF_EN only)
//   stall_count_out    out  saturating count of backpressured cycles (INST_FETCH_PERF_EN only)
//
// Configuration macro:
//   INST_FETCH_PERF_EN - adds the two performance counters above.

module inst_fetch_ctrl #(
    parameter int                     ADDR_WIDTH = 64,
    parameter int                     DATA_WIDTH = 32,
    parameter int                     DEPTH_2POW = 10,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    output logic [ADDR_WIDTH-1:0] mem_address_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  redirect_valid_in,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
    output logic                  inst_valid_out,
    input  logic                  inst_ready_in,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc_out,
    output logic                  inst_fault_out
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]           issued_count_out,
    output logic [31:0]           stall_count_out
`endif
);

    // First byte address past the end of instruction memory.
    localparam logic [ADDR_WIDTH-1:0] LP_LIMIT = ADDR_WIDTH'(1) << (DEPTH_2POW + 2);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
        logic                  fault;
    } entry_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [1:0]            r_count;
    // Slot 0 is always the head; slot 1 shifts down on a pop. Empty slots
    // are held at zero so the head outputs read 0 when the buffer is empty.
    entry_t                r_slot0;
    entry_t                r_slot1;

    logic                  w_redirect;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_fetch;
    logic                  w_legal;
    entry_t                w_new;

    // ------------------------------------------------------------------
    // Fetch / pop decisions
    // ------------------------------------------------------------------
    assign w_redirect = redirect_valid_in;
    assign w_valid    = (r_count != 2'd0);

    // A redirect cycle discards the presented head, so it never counts as a pop.
    assign w_pop      = w_valid && inst_ready_in && !w_redirect;

    // A full buffer can still accept a new word when the head leaves this cycle.
    assign w_fetch    = (r_state == ST_RUN) && !w_redirect
                        && ((r_count != 2'd2) || w_pop);

    // fetch_pc + 4 may wrap to a small value; the range check below is what
    // guarantees the wrapped PC is never presented to memory, because the
    // PC only advances after a legal fetch of the last word, which lands on
    // LP_LIMIT (illegal) long before any wrap is possible for sane widths.
    assign w_legal    = (r_fetch_pc[1:0] == 2'b00) && (r_fetch_pc < LP_LIMIT);

    assign w_new.inst  = w_legal ? mem_data_in : '0;
    assign w_new.pc    = r_fetch_pc;
    assign w_new.fault = !w_legal;

    assign mem_address_out = (w_fetch && w_legal) ? r_fetch_pc : '0;

    // ------------------------------------------------------------------
    // Head outputs straight from the head slot register
    // ------------------------------------------------------------------
    assign inst_valid_out = w_valid;
    assign inst_out       = r_slot0.inst;
    assign inst_pc_out    = r_slot0.pc;
    assign inst_fault_out = r_slot0.fault;

    // ------------------------------------------------------------------
    // FSM, fetch PC and prefetch buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_count    <= 2'd0;
            r_slot0    <= '0;
            r_slot1    <= '0;
        end else if (w_redirect) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= redirect_pc_in;
            r_count    <= 2'd0;
            r_slot0    <= '0;
            r_slot1    <= '0;
        end else begin
            if (w_fetch) begin
                if (w_legal) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                end else begin
                    // Fault entry is pushed once; the PC is held so the
                    // faulting address stays visible until a redirect.
                    r_state <= ST_FAULT;
                end
            end

            case ({w_fetch, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= w_new;
                    end else begin
                        r_slot1 <= w_new;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // With one entry, slot 1 is already zero, which empties slot 0.
                    r_slot0 <= r_slot1;
                    r_slot1 <= '0;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_slot0 <= w_new;
                    end else begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= w_new;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef INST_FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters: saturating, cleared only by reset
    // ------------------------------------------------------------------
    logic [31:0] r_issued_count;
    logic [31:0] r_stall_count;
    logic        w_stall;

    assign w_stall = w_valid && !inst_ready_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_issued_count <= 32'd0;
            r_stall_count  <= 32'd0;
        end else begin
            if (w_pop && (r_issued_count != 32'hFFFF_FFFF)) begin
                r_issued_count <= r_issued_count + 32'd1;
            end
            if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign issued_count_out = r_issued_count;
    assign stall_count_out  = r_stall_count;
`endif

endmodule
